// File: rtl/mem_bus_arbiter.sv
// Two-requester (fetch / load-store) arbiter for a single external memory port.
// Optional access timeout enabled by defining MEM_BUS_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              mem_req_i,
    input  logic              mem_we_i,
    input  logic [3:0]        mem_sel_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_rdata_o,
    output logic              mem_ack_o,
    output logic              bus_ce_o,
    output logic              bus_we_o,
    output logic [3:0]        bus_sel_o,
    output logic [ADDR_W-1:0] bus_addr_o,
    output logic [DATA_W-1:0] bus_wdata_o,
    input  logic [DATA_W-1:0] bus_rdata_i,
    input  logic              bus_ready_i,
    output logic              pausereq_if_o,
    output logic              pausereq_mem_o,
    output logic              err_o,
    output logic [1:0]        dbg_state_o
);

    // Handshake: a requester raises req and holds it (with stable payload) until its
    // ack pulse; the bus side is done when bus_ready_i is high while bus_ce_o is high.

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    if (STARVE_MAX < 1 || STARVE_MAX > 15 || TIMEOUT < 1) begin : g_bad_param
        $error("mem_bus_arbiter: STARVE_MAX must be 1..15 and TIMEOUT >= 1");
    end

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t            state;
    logic              owner_mem;
    logic [3:0]        starve_cnt;
    logic              grant_mem;
    logic              access_end;
    logic [DATA_W-1:0] end_rdata;

    // IF only overrides MEM once it has been passed over STARVE_MAX times in a row.
    assign grant_mem = mem_req_i && !(if_req_i && (starve_cnt == STARVE_LIM));

`ifdef MEM_BUS_ARB_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    logic [TMR_W-1:0] timer;
    logic             timed_out;
    logic             err_r;

    assign timed_out  = (timer == TMR_W'(TIMEOUT - 1));
    assign access_end = bus_ready_i | timed_out;
    assign end_rdata  = bus_ready_i ? bus_rdata_i : '0;
    assign err_o      = err_r;
`else
    assign access_end = bus_ready_i;
    assign end_rdata  = bus_rdata_i;
    assign err_o      = 1'b0;
`endif

    assign pausereq_if_o  = if_req_i & ~if_ack_o;
    assign pausereq_mem_o = mem_req_i & ~mem_ack_o;
    assign dbg_state_o    = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            owner_mem   <= 1'b0;
            starve_cnt  <= '0;
            bus_ce_o    <= 1'b0;
            bus_we_o    <= 1'b0;
            bus_sel_o   <= '0;
            bus_addr_o  <= '0;
            bus_wdata_o <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            timer       <= '0;
            err_r       <= 1'b0;
`endif
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
            err_r     <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (if_req_i || mem_req_i) begin
                        owner_mem <= grant_mem;
                        bus_ce_o  <= 1'b1;
                        state     <= ACCESS;
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                        timer     <= '0;
`endif
                        if (grant_mem) begin
                            bus_we_o    <= mem_we_i;
                            bus_sel_o   <= mem_sel_i;
                            bus_addr_o  <= mem_addr_i;
                            bus_wdata_o <= mem_wdata_i;
                            if (if_req_i && (starve_cnt != STARVE_LIM)) begin
                                starve_cnt <= starve_cnt + 4'd1;
                            end
                        end else begin
                            bus_we_o    <= 1'b0;
                            bus_sel_o   <= 4'hF;
                            bus_addr_o  <= if_addr_i;
                            bus_wdata_o <= '0;
                            starve_cnt  <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (access_end) begin
                        bus_ce_o <= 1'b0;
                        state    <= DONE;
                        if (owner_mem) begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= end_rdata;
                        end else begin
                            if_ack_o    <= 1'b1;
                            if_rdata_o  <= end_rdata;
                        end
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                        err_r <= ~bus_ready_i;
`endif
                    end
`ifdef MEM_BUS_ARB_TIMEOUT_EN
                    else begin
                        timer <= timer + TMR_W'(1);
                    end
`endif
                end
                DONE: begin
                    // Turnaround cycle lets the acked requester drop or replace its request.
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: requester drivers, memory model and
// scoreboard queues for grant order and per-requester ack data.
module tb_mem_bus_arbiter;

    localparam int TIMEOUT = 16;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_addr_i = '0;
    logic [31:0] if_rdata_o;
    logic        if_ack_o;
    logic        mem_req_i = 1'b0;
    logic        mem_we_i = 1'b0;
    logic [3:0]  mem_sel_i = '0;
    logic [31:0] mem_addr_i = '0;
    logic [31:0] mem_wdata_i = '0;
    logic [31:0] mem_rdata_o;
    logic        mem_ack_o;
    logic        bus_ce_o;
    logic        bus_we_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [31:0] bus_rdata_i = '0;
    logic        bus_ready_i = 1'b0;
    logic        pausereq_if_o;
    logic        pausereq_mem_o;
    logic        err_o;
    logic [1:0]  dbg_state_o;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i), .mem_addr_i(mem_addr_i),
        .mem_wdata_i(mem_wdata_i), .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
        .bus_ce_o(bus_ce_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ready_i(bus_ready_i),
        .pausereq_if_o(pausereq_if_o), .pausereq_mem_o(pausereq_mem_o), .err_o(err_o),
        .dbg_state_o(dbg_state_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          failures = 0;
    req_t        if_q[$];
    req_t        mem_q[$];
    req_t        grant_exp_q[$];
    logic [31:0] if_exp_q[$];
    logic [31:0] mem_exp_q[$];

    int wait_cfg = 0;
    int wait_cnt = 0;
    bit expect_err = 1'b0;
    bit perturb = 1'b0;
    bit if_busy = 1'b0;
    bit mem_busy = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mem_fn(input logic [31:0] addr);
        if (addr == 32'h100) return 32'h2401_0005;
        return {addr[15:0], ~addr[15:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic push_if(input logic [31:0] addr, input logic [31:0] exp_rdata);
        if_q.push_back('{we: 1'b0, sel: 4'hF, addr: addr, wdata: 32'h0});
        if_exp_q.push_back(exp_rdata);
    endtask

    task automatic push_mem(input logic [31:0] addr, input logic we, input logic [3:0] sel,
                            input logic [31:0] wdata);
        mem_q.push_back('{we: we, sel: sel, addr: addr, wdata: wdata});
        mem_exp_q.push_back(mem_fn(addr));
    endtask

    task automatic expect_grant(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                                input logic [31:0] wdata);
        grant_exp_q.push_back('{we: we, sel: sel, addr: addr, wdata: wdata});
    endtask

    task automatic wait_quiet(input int budget);
        int n = 0;
        while (n < budget && !(if_q.size() == 0 && mem_q.size() == 0 && !if_busy && !mem_busy &&
               grant_exp_q.size() == 0 && !bus_ce_o && dbg_state_o == 2'd0)) begin
            step();
            n++;
        end
        check_eq("quiet_within_budget", 32'(n < budget), 1);
        repeat (3) step();
    endtask

    // ---------------- monitor, requesters, memory model ----------------
    logic prev_ce = 1'b0;
    logic prev_ready = 1'b0;
    logic prev_if_ack = 1'b0;
    logic prev_mem_ack = 1'b0;
    req_t bus_snap;
    int   access_cycles = 0;

    always @(negedge clk) begin
        req_t g;
        req_t r;
        if (rst) begin
            check_eq("pausereq_if", pausereq_if_o, if_req_i & ~if_ack_o);
            check_eq("pausereq_mem", pausereq_mem_o, mem_req_i & ~mem_ack_o);
            if (bus_ce_o && !prev_ce) begin
                access_cycles = 1;
                check_eq("state_access", 32'(dbg_state_o), 1);
                check_eq("grant_expected", 32'(grant_exp_q.size() != 0), 1);
                if (grant_exp_q.size() != 0) begin
                    g = grant_exp_q.pop_front();
                    check_eq("grant_addr", bus_addr_o, g.addr);
                    check_eq("grant_we", bus_we_o, g.we);
                    check_eq("grant_sel", bus_sel_o, g.sel);
                    if (g.we) check_eq("grant_wdata", bus_wdata_o, g.wdata);
                end
                bus_snap = '{we: bus_we_o, sel: bus_sel_o, addr: bus_addr_o, wdata: bus_wdata_o};
            end else if (bus_ce_o) begin
                access_cycles++;
                check_eq("bus_stable_addr", bus_addr_o, bus_snap.addr);
                check_eq("bus_stable_ctl", {bus_we_o, bus_sel_o}, {bus_snap.we, bus_snap.sel});
                check_eq("bus_stable_wdata", bus_wdata_o, bus_snap.wdata);
            end
            if (prev_ready) check_eq("ack_after_ready", if_ack_o | mem_ack_o, 1);
            check_eq("single_owner_ack", if_ack_o & mem_ack_o, 0);
            if (if_ack_o) begin
                check_eq("if_ack_pulse", prev_if_ack, 0);
                check_eq("if_ack_expected", 32'(if_exp_q.size() != 0), 1);
                if (if_exp_q.size() != 0) check_eq("if_rdata", if_rdata_o, if_exp_q.pop_front());
                check_eq("if_err", err_o, expect_err);
                if (expect_err) check_eq("timeout_cycles", access_cycles, TIMEOUT);
            end
            if (mem_ack_o) begin
                check_eq("mem_ack_pulse", prev_mem_ack, 0);
                check_eq("mem_ack_expected", 32'(mem_exp_q.size() != 0), 1);
                if (mem_exp_q.size() != 0) check_eq("mem_rdata", mem_rdata_o, mem_exp_q.pop_front());
                check_eq("mem_err", err_o, expect_err);
            end
            if (!if_ack_o && !mem_ack_o) check_eq("err_quiet", err_o, 0);

            if (if_ack_o) begin
                if_busy  = 1'b0;
                if_req_i = 1'b0;
            end
            if (mem_ack_o) begin
                mem_busy  = 1'b0;
                mem_req_i = 1'b0;
            end
            // Perturbed requesters drop req and scribble the payload right after grant.
            if (perturb && bus_ce_o && !prev_ce) begin
                mem_req_i   = 1'b0;
                mem_addr_i  = 32'hBAD0_0000;
                mem_wdata_i = 32'h0BAD_F00D;
                mem_we_i    = ~mem_we_i;
            end
            if (!if_busy && if_q.size() != 0) begin
                r = if_q.pop_front();
                if_req_i  = 1'b1;
                if_addr_i = r.addr;
                if_busy   = 1'b1;
            end
            if (!mem_busy && mem_q.size() != 0) begin
                r = mem_q.pop_front();
                mem_req_i   = 1'b1;
                mem_we_i    = r.we;
                mem_sel_i   = r.sel;
                mem_addr_i  = r.addr;
                mem_wdata_i = r.wdata;
                mem_busy    = 1'b1;
            end

            if (bus_ce_o) begin
                if (wait_cnt >= wait_cfg) begin
                    bus_ready_i = 1'b1;
                    bus_rdata_i = mem_fn(bus_addr_o);
                end else begin
                    bus_ready_i = 1'b0;
                    bus_rdata_i = $urandom;
                    wait_cnt++;
                end
            end else begin
                bus_ready_i = 1'b0;
                bus_rdata_i = $urandom;
                wait_cnt = 0;
            end
            prev_ready = bus_ready_i & bus_ce_o;
        end else begin
            bus_ready_i = 1'b0;
            wait_cnt = 0;
            prev_ready = 1'b0;
        end
        prev_ce      = bus_ce_o;
        prev_if_ack  = if_ack_o;
        prev_mem_ack = mem_ack_o;
    end

    // ---------------- stimulus ----------------
    initial begin
        #1 rst = 1'b0;
        #1;
        check_eq("rst_bus_ce", bus_ce_o, 0);
        check_eq("rst_bus_ctl", {bus_we_o, bus_sel_o}, 0);
        check_eq("rst_bus_addr", bus_addr_o, 0);
        check_eq("rst_bus_wdata", bus_wdata_o, 0);
        check_eq("rst_acks", {if_ack_o, mem_ack_o, err_o}, 0);
        check_eq("rst_if_rdata", if_rdata_o, 0);
        check_eq("rst_mem_rdata", mem_rdata_o, 0);
        check_eq("rst_state", 32'(dbg_state_o), 0);
        step();
        rst = 1'b1;
        repeat (2) step();

        // Single fetch, zero wait states.
        push_if(32'h100, 32'h2401_0005);
        expect_grant(1'b0, 4'hF, 32'h100, 32'h0);
        wait_quiet(50);

        // Simultaneous requests: MEM store first, IF next.
        push_mem(32'h2000, 1'b1, 4'hF, 32'hDEAD_BEEF);
        push_if(32'h104, mem_fn(32'h104));
        expect_grant(1'b1, 4'hF, 32'h2000, 32'hDEAD_BEEF);
        expect_grant(1'b0, 4'hF, 32'h104, 32'h0);
        wait_quiet(50);

        // Starvation, twice: second round shows the counter restarted from zero.
        for (int round = 0; round < 2; round++) begin
            logic [31:0] wd[6];
            logic [3:0]  sl[6];
            push_if(32'h200 + 32'(round * 4), mem_fn(32'h200 + 32'(round * 4)));
            for (int i = 0; i < 6; i++) begin
                wd[i] = $urandom;
                sl[i] = 4'($urandom_range(1, 15));
                push_mem(32'h3000 + 32'(i * 4), 1'(i), sl[i], wd[i]);
            end
            for (int i = 0; i < 4; i++) expect_grant(1'(i), sl[i], 32'h3000 + 32'(i * 4), wd[i]);
            expect_grant(1'b0, 4'hF, 32'h200 + 32'(round * 4), 32'h0);
            for (int i = 4; i < 6; i++) expect_grant(1'(i), sl[i], 32'h3000 + 32'(i * 4), wd[i]);
            wait_quiet(200);
        end

        // Wait states: fetch with requester held, then load with requester perturbed mid-access.
        wait_cfg = 5;
        push_if(32'h400, mem_fn(32'h400));
        expect_grant(1'b0, 4'hF, 32'h400, 32'h0);
        wait_quiet(60);
        perturb = 1'b1;
        push_mem(32'h500, 1'b0, 4'h3, 32'h1234_5678);
        expect_grant(1'b0, 4'h3, 32'h500, 32'h1234_5678);
        wait_quiet(60);
        perturb = 1'b0;

        // Random single requests with random wait states.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] a;
            logic [31:0] wd;
            logic [3:0]  sl;
            wait_cfg = $urandom_range(0, 3);
            a  = {16'h0, 14'($urandom), 2'b00};
            wd = $urandom;
            sl = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 1) == 1) begin
                push_if(a, mem_fn(a));
                expect_grant(1'b0, 4'hF, a, 32'h0);
            end else begin
                push_mem(a, 1'(i), sl, wd);
                expect_grant(1'(i), sl, a, wd);
            end
            wait_quiet(60);
        end

        // Reset during ACCESS: access abandoned, request re-granted afterwards.
        wait_cfg = 20;
        push_if(32'h700, mem_fn(32'h700));
        expect_grant(1'b0, 4'hF, 32'h700, 32'h0);
        expect_grant(1'b0, 4'hF, 32'h700, 32'h0);
        for (int n = 0; n < 20 && !bus_ce_o; n++) step();
        check_eq("reset_test_granted", bus_ce_o, 1);
        repeat (2) step();
        rst = 1'b0;
        #1;
        check_eq("midrst_bus_ce", bus_ce_o, 0);
        check_eq("midrst_acks", {if_ack_o, mem_ack_o}, 0);
        check_eq("midrst_state", 32'(dbg_state_o), 0);
        repeat (3) step();
        check_eq("midrst_held_acks", {if_ack_o, mem_ack_o}, 0);
        wait_cfg = 0;
        rst = 1'b1;
        wait_quiet(50);

`ifdef MEM_BUS_ARB_TIMEOUT_EN
        // Memory never answers: abort after TIMEOUT access cycles.
        wait_cfg = 1000;
        expect_err = 1'b1;
        push_if(32'h600, 32'h0);
        expect_grant(1'b0, 4'hF, 32'h600, 32'h0);
        wait_quiet(100);
        expect_err = 1'b0;
        wait_cfg = 0;
        push_if(32'h604, mem_fn(32'h604));
        expect_grant(1'b0, 4'hF, 32'h604, 32'h0);
        wait_quiet(50);
`endif

        check_eq("left_grants", grant_exp_q.size(), 0);
        check_eq("left_if_acks", if_exp_q.size(), 0);
        check_eq("left_mem_acks", mem_exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one external memory port between the instruction-fetch requester (IF) and the load/store requester (MEM) of the five-stage pipeline.
- Grants one requester at a time and holds the bus until the memory signals ready.
- Returns read data and a one-cycle acknowledge to the granted requester.
- Raises per-requester pause requests toward the pipeline stall controller while a request is outstanding.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.
- STARVE_MAX, 4, consecutive MEM grants allowed while IF is waiting; range 1..15.
- TIMEOUT, 16, cycles to wait for bus_ready_i before abort. Used only with the optional feature.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- if_req_i  in  1  fetch request; held high until if_ack_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_rdata_o  out  DATA_W  fetched word; valid while if_ack_o=1.
- if_ack_o  out  1  one-cycle fetch-complete pulse.
- mem_req_i  in  1  data request; held high until mem_ack_o.
- mem_we_i  in  1  1 = store, 0 = load.
- mem_sel_i  in  4  byte enables.
- mem_addr_i  in  ADDR_W  data address.
- mem_wdata_i  in  DATA_W  store data.
- mem_rdata_o  out  DATA_W  load data; valid while mem_ack_o=1.
- mem_ack_o  out  1  one-cycle data-complete pulse.
- bus_ce_o  out  1  memory access strobe.
- bus_we_o  out  1  memory write enable.
- bus_sel_o  out  4  memory byte enables.
- bus_addr_o  out  ADDR_W  memory address.
- bus_wdata_o  out  DATA_W  memory write data.
- bus_rdata_i  in  DATA_W  memory read data; valid with bus_ready_i.
- bus_ready_i  in  1  memory access complete.
- pausereq_if_o  out  1  stall request for the fetch side.
- pausereq_mem_o  out  1  stall request for the memory side.
- err_o  out  1  timeout pulse. Constant 0 when the optional feature is off.

Behaviour:
- Reset (rst=0, asynchronous, any state): FSM goes to IDLE, starve_cnt=0. All registered outputs go to 0: bus_ce_o, bus_we_o, bus_sel_o, bus_addr_o, bus_wdata_o, if_ack_o, mem_ack_o, if_rdata_o, mem_rdata_o, err_o. An access in flight is abandoned and no ack is issued.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no request: stay in IDLE; bus_ce_o=0.
- IDLE, request present: choose owner, latch that requester's address/we/sel/wdata onto the bus_* registers, set bus_ce_o=1, go to ACCESS. IF requests drive bus_we_o=0 and bus_sel_o=4'hF.
- Owner choice: MEM wins when both request, unless starve_cnt==STARVE_MAX, in which case IF wins.
- starve_cnt: +1 on each MEM grant made while if_req_i=1; cleared on any IF grant; saturates at STARVE_MAX.
- ACCESS: bus outputs held stable. When bus_ready_i=1, capture bus_rdata_i into the owner's rdata_o, pulse the owner's ack_o for one cycle, drop bus_ce_o, go to DONE. With bus_ready_i=0 the FSM stays in ACCESS indefinitely (optional feature aside).
- DONE: ack deasserts; go to IDLE. This is a one-cycle turnaround so the requester can drop or change its request.
- Minimum latency: request seen at edge N; bus_ce_o=1 after N; bus_ready_i in the same cycle gives ack after edge N+1; next grant at edge N+3.
- Store acks: rdata_o is the captured bus_rdata_i, don't-care to the requester.
- Non-owner rdata_o holds its last value.
- pausereq_if_o = if_req_i & ~if_ack_o, combinational. pausereq_mem_o = mem_req_i & ~mem_ack_o, likewise.
- Requester drops req during ACCESS: the access still completes and the ack is still pulsed.
- Requester changes address mid-access: no effect, because the bus_* values are latched at grant.
- Never both acks in one cycle.

Optional Feature:
- Macro: MEM_BUS_ARB_TIMEOUT_EN.
- Defined: a cycle counter runs in ACCESS. If bus_ready_i has not been seen after TIMEOUT cycles, abort the access: owner ack_o=1, owner rdata_o=0, err_o=1 for one cycle, bus_ce_o=0, go to DONE. The counter clears on every grant.
- Undefined: no counter; err_o tied to 0; ACCESS waits indefinitely.

Test Plan:
- Single fetch: if_req_i=1 with if_addr_i=0x100, memory ready on the first ACCESS cycle returning 0x24010005 -> bus_addr_o=0x100, bus_we_o=0; if_ack_o is a single pulse with if_rdata_o=0x24010005; pausereq_if_o=0 in the ack cycle.
- Simultaneous requests: if_req_i and mem_req_i both 1, mem_we_i=1, addr 0x2000, wdata 0xDEADBEEF -> MEM granted first with bus_we_o=1 and bus_wdata_o=0xDEADBEEF; IF granted in the next IDLE.
- Starvation, STARVE_MAX=4: IF held high while MEM re-requests continuously -> exactly 4 MEM grants, then an IF grant, then starve_cnt=0.
- Wait states: bus_ready_i delayed 5 cycles -> bus outputs stable for 5 cycles; ack arrives 1 cycle after ready; pausereq high throughout.
- Reset mid-access: rst=0 during ACCESS -> next sample shows bus_ce_o=0 and no acks; after release, a pending request is re-granted from IDLE.
- Timeout, MEM_BUS_ARB_TIMEOUT_EN defined, TIMEOUT=16, bus_ready_i never asserted -> after 16 ACCESS cycles, ack=1, rdata_o=0, err_o=1 for one cycle; the FSM returns to IDLE.
